// File: rtl/iir_out_requant.sv
// iir_out_requant
// Requantizes the wide Q(WI_IN).(WF_IN) output of the IIR SOS cascade to a
// narrow Q(WI_OUT).(WF_OUT) sample. It rounds half-up (toward +inf), clips to
// the signed output range, and queues the result in a small FIFO that sits
// behind a valid/ready handshake.
//
// Ports:
//   CLK         system clock, all state on the rising edge
//   nReset      synchronous active-low reset
//   CE          Filt_In / ovf_in carry a new filter sample this cycle
//   Filt_In     filter output, signed fixed point
//   ovf_in      filter overflow flag, qualified by CE
//   out_data    FIFO head sample; holds its last value while the FIFO is empty
//   out_valid   FIFO non-empty
//   out_ready   consumer takes the head when out_valid && out_ready
//   sat_flag    one-cycle pulse when a saturated sample is pushed or dropped
//   ovf_sticky  latched overflow/saturation indicator
//   clr_sticky  clears ovf_sticky (a set in the same cycle wins)
//   sat_count   saturated-sample count, stops at 0xFFFF
//   drop_count  samples dropped on a full FIFO, stops at 0xFF
module iir_out_requant #(
  parameter int WI_IN  = 12,
  parameter int WF_IN  = 24,
  parameter int WI_OUT = 3,
  parameter int WF_OUT = 7,
  parameter int DEPTH  = 4
) (
  input  logic                     CLK,
  input  logic                     nReset,
  input  logic                     CE,
  input  logic [WI_IN+WF_IN-1:0]   Filt_In,
  input  logic                     ovf_in,
  output logic [WI_OUT+WF_OUT-1:0] out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     sat_flag,
  output logic                     ovf_sticky,
  input  logic                     clr_sticky,
  output logic [15:0]              sat_count,
  output logic [7:0]               drop_count
);

  localparam int WIN = WI_IN + WF_IN;
  localparam int WO  = WI_OUT + WF_OUT;
  localparam int SH  = WF_IN - WF_OUT;
  localparam int W1  = WI_IN + WF_OUT + 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = AW + 1;

  // Half an output LSB expressed in input LSBs, one bit wider than the input
  localparam logic [WIN:0] HALF = {{(WIN-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [W1-1:0] MAXW = {{(W1-WO+1){1'b0}}, {(WO-1){1'b1}}};
  localparam logic signed [W1-1:0] MINW = {{(W1-WO+1){1'b1}}, {(WO-1){1'b0}}};
  localparam logic [CW-1:0] FULLCNT = CW'(DEPTH);

  // Pipeline registers
  logic                 v1_q, v2_q, sat2_q;
  logic signed [W1-1:0] r1_q;
  logic [WO-1:0]        s2Data_q;

  // FIFO and status registers
  logic [WO-1:0] mem_q [DEPTH];
  logic [AW-1:0] wrPtr_q, rdPtr_q;
  logic [CW-1:0] count_q, count_d;
  logic [WO-1:0] head_q, head_d;
  logic          satFlag_q, sticky_q;
  logic [15:0]   satCnt_q;
  logic [7:0]    dropCnt_q;

  logic [WIN:0]         rndSum;
  logic signed [W1-1:0] r1_d;
  logic [WO-1:0]        s2Data_d;
  logic                 sat2_d;
  logic                 full, pop, pushAcc, drop, satEvent, stickySet;
  logic [AW-1:0]        rdNext;
  logic                 unusedLowBits;

  // Rounding: add half an output LSB to the sign-extended input, then keep
  // the bits above the shift. Taking the upper slice is the arithmetic shift,
  // and the extra top bit means the add can never wrap.
  assign rndSum        = {Filt_In[WIN-1], Filt_In} + HALF;
  assign r1_d          = rndSum[SH +: W1];
  assign unusedLowBits = ^rndSum[SH-1:0];

  // Clip the rounded value into the output range and flag when clipping occurred
  always_comb begin
    s2Data_d = r1_q[WO-1:0];
    sat2_d   = 1'b0;
    if (r1_q > MAXW) begin
      s2Data_d = MAXW[WO-1:0];
      sat2_d   = 1'b1;
    end else if (r1_q < MINW) begin
      s2Data_d = MINW[WO-1:0];
      sat2_d   = 1'b1;
    end
  end

  // FIFO control. When full, a pop in the same cycle frees the slot the push
  // needs, so the push is accepted instead of being dropped.
  assign full      = (count_q == FULLCNT);
  assign pop       = (count_q != '0) && out_ready;
  assign pushAcc   = v2_q && (!full || pop);
  assign drop      = v2_q && full && !pop;
  assign satEvent  = v2_q && sat2_q;
  assign stickySet = (CE && ovf_in) || satEvent;
  assign rdNext    = rdPtr_q + AW'(1);

  // Occupancy and the registered head word. The head is kept in its own
  // register so out_data keeps the last sample shown once the FIFO drains.
  always_comb begin
    count_d = count_q;
    if (pushAcc && !pop) begin
      count_d = count_q + CW'(1);
    end else if (!pushAcc && pop) begin
      count_d = count_q - CW'(1);
    end

    head_d = head_q;
    if (pop) begin
      if (count_q >= CW'(2)) begin
        head_d = mem_q[rdNext];
      end else if (pushAcc) begin
        head_d = s2Data_q;
      end
    end else if ((count_q == '0) && pushAcc) begin
      head_d = s2Data_q;
    end
  end

  // All state, with a synchronous active-low reset that flushes the pipeline,
  // the FIFO contents and every status output
  always_ff @(posedge CLK) begin
    if (!nReset) begin
      v1_q      <= 1'b0;
      r1_q      <= '0;
      v2_q      <= 1'b0;
      sat2_q    <= 1'b0;
      s2Data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      head_q    <= '0;
      satFlag_q <= 1'b0;
      sticky_q  <= 1'b0;
      satCnt_q  <= '0;
      dropCnt_q <= '0;
    end else begin
      v1_q <= CE;
      if (CE) begin
        r1_q <= r1_d;
      end
      v2_q <= v1_q;
      if (v1_q) begin
        s2Data_q <= s2Data_d;
        sat2_q   <= sat2_d;
      end

      if (pushAcc) begin
        mem_q[wrPtr_q] <= s2Data_q;
        wrPtr_q        <= wrPtr_q + AW'(1);
      end
      if (pop) begin
        rdPtr_q <= rdNext;
      end
      count_q <= count_d;
      head_q  <= head_d;

      satFlag_q <= satEvent;
      if (satEvent && (satCnt_q != 16'hFFFF)) begin
        satCnt_q <= satCnt_q + 16'd1;
      end
      if (drop && (dropCnt_q != 8'hFF)) begin
        dropCnt_q <= dropCnt_q + 8'd1;
      end

      if (stickySet) begin
        sticky_q <= 1'b1;
      end else if (clr_sticky) begin
        sticky_q <= 1'b0;
      end
    end
  end

  assign out_data   = head_q;
  assign out_valid  = (count_q != '0);
  assign sat_flag   = satFlag_q;
  assign ovf_sticky = sticky_q;
  assign sat_count  = satCnt_q;
  assign drop_count = dropCnt_q;

endmodule

// File: tb/tb_iir_out_requant.sv
// tb_iir_out_requant
// Directed and randomized stimulus for iir_out_requant. A reference model
// built from fixed-point arithmetic and a queue predicts every output after
// each clock edge; a few directed steps also compare against hand-derived
// constants.
module tb_iir_out_requant;

  localparam int WI_IN  = 12;
  localparam int WF_IN  = 24;
  localparam int WI_OUT = 3;
  localparam int WF_OUT = 7;
  localparam int DEPTH  = 4;
  localparam int WIN    = WI_IN + WF_IN;
  localparam int WO     = WI_OUT + WF_OUT;
  localparam int SH     = WF_IN - WF_OUT;

  logic           CLK;
  logic           nReset;
  logic           CE;
  logic [WIN-1:0] Filt_In;
  logic           ovf_in;
  logic [WO-1:0]  out_data;
  logic           out_valid;
  logic           out_ready;
  logic           sat_flag;
  logic           ovf_sticky;
  logic           clr_sticky;
  logic [15:0]    sat_count;
  logic [7:0]     drop_count;

  iir_out_requant #(
    .WI_IN(WI_IN), .WF_IN(WF_IN), .WI_OUT(WI_OUT), .WF_OUT(WF_OUT), .DEPTH(DEPTH)
  ) dut (
    .CLK(CLK),
    .nReset(nReset),
    .CE(CE),
    .Filt_In(Filt_In),
    .ovf_in(ovf_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sat_flag(sat_flag),
    .ovf_sticky(ovf_sticky),
    .clr_sticky(clr_sticky),
    .sat_count(sat_count),
    .drop_count(drop_count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic          valid;
    logic          sat;
    logic [WO-1:0] data;
  } stageT;

  // Reference model state
  stageT         p1, p2;
  logic [WO-1:0] fifoQ[$];
  logic [WO-1:0] lastHead;
  logic          expSatFlag;
  logic          expSticky;
  int            expSatCnt;
  int            expDropCnt;
  longint        curX;

  int passCount  = 0;
  int totalCount = 0;

  // Real-valued requantization: round(x * 2^WF_OUT / 2^WF_IN) half-up via
  // floor((x + half) / 2^SH), then clip to the output range
  task automatic requant(input longint x, output logic [WO-1:0] val, output logic sat);
    longint divisor, num, q, maxV, minV;
    divisor = 64'sd1 <<< SH;
    maxV    = (64'sd1 <<< (WO - 1)) - 1;
    minV    = -(64'sd1 <<< (WO - 1));
    num     = x + divisor / 2;
    q       = num / divisor;
    if ((num % divisor != 0) && (num < 0)) q = q - 1;
    sat = 1'b0;
    if (q > maxV) begin
      q   = maxV;
      sat = 1'b1;
    end else if (q < minV) begin
      q   = minV;
      sat = 1'b1;
    end
    val = q[WO-1:0];
  endtask

  // Advance the model by one clock edge using the inputs present at that edge
  task automatic modelStep();
    logic          popNow, setNow;
    logic [WO-1:0] v;
    logic          s;
    if (!nReset) begin
      p1         = '0;
      p2         = '0;
      fifoQ.delete();
      lastHead   = '0;
      expSatFlag = 1'b0;
      expSticky  = 1'b0;
      expSatCnt  = 0;
      expDropCnt = 0;
    end else begin
      popNow     = (fifoQ.size() > 0) && out_ready;
      expSatFlag = p2.valid && p2.sat;
      if (expSatFlag && expSatCnt < 65535) expSatCnt++;
      if (popNow) void'(fifoQ.pop_front());
      if (p2.valid) begin
        if (fifoQ.size() < DEPTH) fifoQ.push_back(p2.data);
        else if (expDropCnt < 255) expDropCnt++;
      end
      setNow = (CE && ovf_in) || expSatFlag;
      if (setNow) expSticky = 1'b1;
      else if (clr_sticky) expSticky = 1'b0;
      p2 = p1;
      p1 = '0;
      if (CE) begin
        requant(curX, v, s);
        p1.valid = 1'b1;
        p1.sat   = s;
        p1.data  = v;
      end
      if (fifoQ.size() > 0) lastHead = fifoQ[0];
    end
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic checkOutput();
    checkVal("out_valid",  32'(out_valid),  32'(fifoQ.size() > 0));
    checkVal("out_data",   32'(out_data),   32'(lastHead));
    checkVal("sat_flag",   32'(sat_flag),   32'(expSatFlag));
    checkVal("ovf_sticky", 32'(ovf_sticky), 32'(expSticky));
    checkVal("sat_count",  32'(sat_count),  32'(expSatCnt));
    checkVal("drop_count", 32'(drop_count), 32'(expDropCnt));
  endtask

  task automatic tick();
    @(posedge CLK);
    modelStep();
    #1;
    checkOutput();
  endtask

  task automatic applyStimulus(input logic ce, input longint x, input logic ovf,
                               input logic clr, input logic rdy);
    CE         = ce;
    curX       = x;
    Filt_In    = x[WIN-1:0];
    ovf_in     = ovf;
    clr_sticky = clr;
    out_ready  = rdy;
    tick();
  endtask

  // One sample through an empty FIFO with out_ready high, checked at k+2
  task automatic roundCase(input string tag, input longint x, input logic [WO-1:0] exp,
                           input logic expSat);
    applyStimulus(1'b1, x, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    checkVal({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkVal({tag, "_data"},  32'(out_data),  32'(exp));
    checkVal({tag, "_sat"},   32'(sat_flag),  32'(expSat));
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  localparam longint ONE = 64'sd1 <<< WF_IN;
  localparam longint LSB = 64'sd1 <<< SH;

  initial begin
    p1 = '0; p2 = '0; lastHead = '0;
    expSatFlag = 1'b0; expSticky = 1'b0; expSatCnt = 0; expDropCnt = 0;
    nReset = 1'b0; CE = 1'b0; curX = 0; Filt_In = '0; ovf_in = 1'b0;
    clr_sticky = 1'b0; out_ready = 1'b0;

    // Reset held for two cycles with a live sample on the input
    $display("[TB] reset");
    applyStimulus(1'b1, 64'h0_0180_0000, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b1, 64'h0_0180_0000, 1'b0, 1'b0, 1'b1);
    checkVal("rst_data",  32'(out_data),   32'd0);
    checkVal("rst_valid", 32'(out_valid),  32'd0);
    checkVal("rst_cnt",   32'(sat_count),  32'd0);
    nReset = 1'b1;

    // Latency: first sample after release appears exactly two edges later
    applyStimulus(1'b1, 64'h0_0180_0000, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkVal("lat_k1", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkVal("lat_k2", 32'(out_valid), 32'd1);
    checkVal("lat_k2_data", 32'(out_data), 32'h0C0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Rounding and saturation with hand-derived results
    $display("[TB] rounding and saturation");
    roundCase("r_1p5",  3 * ONE / 2,            10'h0C0, 1'b0);
    roundCase("r_p2m8", ONE / 256,              10'h001, 1'b0);
    roundCase("r_m2m8", -(ONE / 256),           10'h000, 1'b0);
    roundCase("r_m3",   -(ONE / 128 + ONE / 256), 10'h3FF, 1'b0);
    roundCase("s_p5",   5 * ONE,                10'h1FF, 1'b1);
    checkVal("s_p5_cnt",    32'(sat_count),  32'd1);
    checkVal("s_p5_sticky", 32'(ovf_sticky), 32'd1);
    roundCase("s_m6",   -6 * ONE,               10'h200, 1'b1);
    checkVal("s_m6_cnt",    32'(sat_count),  32'd2);
    roundCase("s_max",  511 * LSB,              10'h1FF, 1'b0);
    checkVal("s_max_cnt",   32'(sat_count),  32'd2);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);

    // Backpressure: six samples into a stalled FIFO, two are dropped
    $display("[TB] backpressure");
    for (int i = 1; i <= 6; i++) applyStimulus(1'b1, i * LSB, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkVal("bp_drops", 32'(drop_count), 32'd2);
    for (int i = 1; i <= 4; i++) begin
      checkVal("bp_order", 32'(out_data), 32'(i));
      applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    end
    checkVal("bp_empty", 32'(out_valid), 32'd0);

    // Full FIFO with a continuous stream and a ready consumer: no drops
    $display("[TB] full with push and pop");
    for (int i = 10; i <= 15; i++) applyStimulus(1'b1, i * LSB, 1'b0, 1'b0, 1'b0);
    for (int i = 16; i <= 23; i++) begin
      applyStimulus(1'b1, i * LSB, 1'b0, 1'b0, 1'b1);
      checkVal("full_occ", 32'(fifoQ.size()), 32'(DEPTH));
    end
    checkVal("full_drops", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);

    // Sticky: set beats clear in the same edge, clear alone works next edge
    $display("[TB] sticky");
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(1'b1, 0, 1'b1, 1'b1, 1'b1);
    checkVal("stk_set", 32'(ovf_sticky), 32'd1);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, 1'b1);
    checkVal("stk_clr", 32'(ovf_sticky), 32'd0);

    // Randomized traffic against the model
    $display("[TB] random");
    for (int i = 0; i < 400; i++) begin
      longint x;
      x = longint'(int'($urandom)) >>> $urandom_range(0, 9);
      applyStimulus(1'($urandom_range(0, 3) != 0), x,
                    1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 7) == 0),
                    1'($urandom_range(0, 2) != 0));
    end

    // Reset mid-stream with three entries queued
    $display("[TB] mid-stream reset");
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) applyStimulus(1'b1, i * 7 * LSB, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b0);
    checkVal("mid_queued", 32'(out_valid), 32'd1);
    nReset = 1'b0;
    applyStimulus(1'b1, 5 * ONE, 1'b1, 1'b0, 1'b0);
    checkVal("mid_valid", 32'(out_valid),  32'd0);
    checkVal("mid_sat",   32'(sat_count),  32'd0);
    checkVal("mid_drop",  32'(drop_count), 32'd0);
    nReset = 1'b1;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
